bp_fe_queue_multi_issue: RTL and testbench

BP_FE_QUEUE_MULTI_ISSUE -- requirements
Module: bp_fe_queue_multi_issue

---
 rtl/bp_fe_queue_multi_issue_pkg.sv | 16 +
 rtl/bp_fe_queue_multi_ptr.sv | 18 +
 rtl/bp_fe_queue_multi_issue.sv | 69 ++++++
 tb/tb_bp_fe_queue_multi_issue.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bp_fe_queue_multi_issue_pkg.sv
// bp_fe_queue_multi_issue_pkg: lane-mask helpers shared by the multi-issue fetch queue.
package bp_fe_queue_multi_issue_pkg;
  localparam int max_lanes_lp = 4;

  // Number of consecutive valid lanes starting at lane 0.
  function automatic logic [2:0] lead_ones(input logic [max_lanes_lp-1:0] v);
    lead_ones = '0;
    for (int i = 0; i < max_lanes_lp; i++)
      if (v[i] && lead_ones == 3'(i)) lead_ones = lead_ones + 3'd1;
  endfunction

  // A valid mask is legal only if it is a contiguous run from lane 0 (v+1 is a power of two).
  function automatic logic gappy(input logic [max_lanes_lp-1:0] v);
    return |(v & (v + max_lanes_lp'(1)));
  endfunction
endpackage

// File: rtl/bp_fe_queue_multi_ptr.sv
// bp_fe_queue_multi_ptr: modulo-els_p pointer advancing by 0..lanes_p per cycle.
module bp_fe_queue_multi_ptr #(
  parameter int els_p   = 8,
  parameter int lanes_p = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           clear_i,
  input  logic [$clog2(lanes_p+1)-1:0]   inc_i,
  output logic [$clog2(els_p)-1:0]       ptr_o
);
  localparam int ptr_w = $clog2(els_p);

  // els_p is a power of two, so natural overflow of the add is the modulo wrap.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) ptr_o <= '0;
    else            ptr_o <= clear_i ? '0 : ptr_o + ptr_w'(inc_i);
endmodule

// File: rtl/bp_fe_queue_multi_issue.sv
// bp_fe_queue_multi_issue: fetch queue accepting and releasing up to lanes_p entries per cycle.
module bp_fe_queue_multi_issue
  import bp_fe_queue_multi_issue_pkg::*;
#(
  parameter int width_p = 64,
  parameter int lanes_p = 2,
  parameter int els_p   = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           flush_i,
  input  logic [lanes_p*width_p-1:0]     enq_data_i,
  input  logic [lanes_p-1:0]             enq_v_i,
  output logic                           enq_ready_o,
  output logic [lanes_p*width_p-1:0]     deq_data_o,
  output logic [lanes_p-1:0]             deq_v_o,
  input  logic [$clog2(lanes_p+1)-1:0]   deq_yumi_cnt_i,
  output logic [$clog2(els_p+1)-1:0]     count_o,
  output logic                           err_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);
  localparam int inc_w = $clog2(lanes_p+1);

  logic [ptr_w-1:0]        head, tail;
  logic [inc_w-1:0]        enq_n, yumi_n;
  logic [max_lanes_lp-1:0] enq_v;
  logic                    err_n;
  logic [width_p-1:0]      mem [els_p];

  assign enq_v       = max_lanes_lp'(enq_v_i);
  assign enq_ready_o = reset_n_i && !flush_i && count_o <= cnt_w'(els_p - lanes_p);
  assign enq_n       = enq_ready_o ? inc_w'(lead_ones(enq_v)) : '0;
  assign err_n       = cnt_w'(deq_yumi_cnt_i) > count_o || deq_yumi_cnt_i > inc_w'(lanes_p)
                    || (enq_ready_o && gappy(enq_v));

  // Illegal consume requests are clamped so occupancy can never underflow.
  always_comb begin
    yumi_n = deq_yumi_cnt_i;
    if (yumi_n > inc_w'(lanes_p)) yumi_n = inc_w'(lanes_p);
    if (cnt_w'(yumi_n) > count_o) yumi_n = inc_w'(count_o);
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      count_o <= '0;
      err_o   <= 1'b0;
    end else begin
      count_o <= flush_i ? '0 : count_o + cnt_w'(enq_n) - cnt_w'(yumi_n);
      err_o   <= err_o | err_n;
    end

  always_ff @(posedge clk_i)
    for (int k = 0; k < lanes_p; k++)
      if (inc_w'(k) < enq_n) mem[tail + ptr_w'(k)] <= enq_data_i[k*width_p +: width_p];

  for (genvar g = 0; g < lanes_p; g++) begin : g_rd
    assign deq_data_o[g*width_p +: width_p] = mem[head + ptr_w'(g)];
    assign deq_v_o[g]                       = count_o > cnt_w'(g);
  end

  bp_fe_queue_multi_ptr #(.els_p(els_p), .lanes_p(lanes_p)) head_ptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(flush_i), .inc_i(yumi_n), .ptr_o(head)
  );

  bp_fe_queue_multi_ptr #(.els_p(els_p), .lanes_p(lanes_p)) tail_ptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(flush_i), .inc_i(enq_n), .ptr_o(tail)
  );
endmodule

// File: tb/tb_bp_fe_queue_multi_issue.sv
// tb_bp_fe_queue_multi_issue: directed vectors with a scoreboard of hand-computed post-edge state.
module tb_bp_fe_queue_multi_issue;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [127:0] enq_data;
  logic [1:0]   enq_v;
  logic         enq_ready;
  logic [127:0] deq_data;
  logic [1:0]   deq_v;
  logic [1:0]   yumi;
  logic [3:0]   count;
  logic         err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    int          cnt;
    logic [1:0]  dv;
    logic        rdy;
    logic        err;
    logic [63:0] d0;
    logic [63:0] d1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bp_fe_queue_multi_issue #(.width_p(64), .lanes_p(2), .els_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .enq_data_i(enq_data),
    .enq_v_i(enq_v), .enq_ready_o(enq_ready), .deq_data_o(deq_data), .deq_v_o(deq_v),
    .deq_yumi_cnt_i(yumi), .count_o(count), .err_o(err)
  );

  function automatic logic [63:0] d(input int n);
    return 64'hF00D_0000_0000_0000 + 64'(n);
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Drive one cycle of stimulus and queue the state expected just after the following edge.
  task automatic step(input string nm, input logic f, input logic [1:0] v, input logic [63:0] a,
                      input logic [63:0] b, input logic [1:0] y, input int ecnt,
                      input logic [1:0] edv, input logic erdy, input logic eerr,
                      input logic [63:0] e0, input logic [63:0] e1);
    @(negedge clk);
    flush = f; enq_v = v; enq_data = {b, a}; yumi = y;
    sb.push_back('{nm, ecnt, edv, erdy, eerr, e0, e1});
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset_n = 1'b0; flush = 1'b0; enq_v = 2'b00; yumi = 2'd0;
    #1;
    chk({nm, " err"},   64'(err), 64'd0);
    chk({nm, " count"}, 64'(count), 64'd0);
    chk({nm, " deq_v"}, 64'(deq_v), 64'd0);
    chk({nm, " ready"}, 64'(enq_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk({nm, " ready_after"}, 64'(enq_ready), 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, " ready"}, 64'(enq_ready), 64'(e.rdy));
      chk({e.nm, " err"},   64'(err), 64'(e.err));
      if (e.cnt >= 0) begin
        chk({e.nm, " count"}, 64'(count), 64'(e.cnt));
        chk({e.nm, " deq_v"}, 64'(deq_v), 64'(e.dv));
        if (e.dv[0]) chk({e.nm, " lane0"}, deq_data[63:0], e.d0);
        if (e.dv[1]) chk({e.nm, " lane1"}, deq_data[127:64], e.d1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; enq_v = 2'b00; enq_data = '0; yumi = 2'd0;
    #2;
    chk("rst err",   64'(err), 64'd0);
    chk("rst count", 64'(count), 64'd0);
    chk("rst deq_v", 64'(deq_v), 64'd0);
    chk("rst ready", 64'(enq_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst ready_after", 64'(enq_ready), 64'd1);

    //    name        f  v      a      b      y  cnt dv     rdy err e0     e1
    step("dual",     0, 2'b11, d(1),  d(2),  0, 2,  2'b11, 1,  0,  d(1),  d(2));
    step("enq2",     0, 2'b11, d(3),  d(4),  0, 4,  2'b11, 1,  0,  d(1),  d(2));
    step("enq3",     0, 2'b11, d(5),  d(6),  0, 6,  2'b11, 1,  0,  d(1),  d(2));
    step("full",     0, 2'b11, d(7),  d(8),  0, 8,  2'b11, 0,  0,  d(1),  d(2));
    step("full_ign", 0, 2'b11, d(24), d(25), 0, 8,  2'b11, 0,  0,  d(1),  d(2));
    step("drain1",   0, 2'b00, 0,     0,     2, 6,  2'b11, 1,  0,  d(3),  d(4));
    step("drain2",   0, 2'b00, 0,     0,     2, 4,  2'b11, 1,  0,  d(5),  d(6));
    step("drain3",   0, 2'b00, 0,     0,     2, 2,  2'b11, 1,  0,  d(7),  d(8));
    step("drain4",   0, 2'b00, 0,     0,     1, 1,  2'b01, 1,  0,  d(8),  0);
    step("wrap_enq", 0, 2'b11, d(9),  d(10), 0, 3,  2'b11, 1,  0,  d(8),  d(9));
    step("wrap_deq", 0, 2'b00, 0,     0,     2, 1,  2'b01, 1,  0,  d(10), 0);
    step("sim_pre",  0, 2'b11, d(11), d(12), 0, 3,  2'b11, 1,  0,  d(10), d(11));
    step("sim",      0, 2'b11, d(13), d(14), 2, 3,  2'b11, 1,  0,  d(12), d(13));
    step("sim_post", 0, 2'b00, 0,     0,     1, 2,  2'b11, 1,  0,  d(13), d(14));
    step("fl_pre1",  0, 2'b11, d(15), d(16), 0, 4,  2'b11, 1,  0,  d(13), d(14));
    step("fl_pre2",  0, 2'b01, d(17), 0,     0, 5,  2'b11, 1,  0,  d(13), d(14));
    step("flush",    1, 2'b11, d(18), d(19), 1, 0,  2'b00, 0,  0,  0,     0);
    step("fl_post",  0, 2'b00, 0,     0,     0, 0,  2'b00, 1,  0,  0,     0);
    step("after_fl", 0, 2'b11, d(20), d(21), 0, 2,  2'b11, 1,  0,  d(20), d(21));
    step("err_pre",  0, 2'b00, 0,     0,     1, 1,  2'b01, 1,  0,  d(21), 0);
    step("yumi_ovr", 0, 2'b00, 0,     0,     2, 0,  2'b00, 1,  1,  0,     0);
    step("gap_enq",  0, 2'b10, d(22), d(23), 0, 0,  2'b00, 1,  1,  0,     0);
    step("enq_one",  0, 2'b01, d(26), 0,     0, 1,  2'b01, 1,  1,  d(26), 0);
    do_reset("mid_rst");
    step("gap_err",  0, 2'b10, d(22), d(23), 0, 0,  2'b00, 1,  1,  0,     0);
    do_reset("rst2");
    step("ovr_a",    0, 2'b11, d(1),  d(2),  0, 2,  2'b11, 1,  0,  d(1),  d(2));
    step("ovr_b",    0, 2'b11, d(3),  d(4),  0, 4,  2'b11, 1,  0,  d(1),  d(2));
    step("yumi3",    0, 2'b00, 0,     0,     3, -1, 2'b00, 1,  1,  0,     0);
    step("idle",     0, 2'b00, 0,     0,     0, -1, 2'b00, 1,  1,  0,     0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
